// File: rtl/flex_finger_conditioner_pkg.sv
// Shared finger indices and sample classes for the flex-sensor conditioning and
// finger identification stages.
package flex_finger_conditioner_pkg;

  localparam int NUM_FINGERS = 5;

  localparam logic [2:0] FINGER_THUMB  = 3'd0;
  localparam logic [2:0] FINGER_INDEX  = 3'd1;
  localparam logic [2:0] FINGER_MIDDLE = 3'd2;
  localparam logic [2:0] FINGER_RING   = 3'd3;
  localparam logic [2:0] FINGER_PINKY  = 3'd4;

  typedef enum logic [1:0] {
    CLS_HOLD     = 2'd0,
    CLS_BENT     = 2'd1,
    CLS_STRAIGHT = 2'd2
  } cls_e;

  function automatic logic finger_ok(input logic [2:0] finger);
    return finger <= FINGER_PINKY;
  endfunction

endpackage

// File: rtl/flex_finger_conditioner_if.sv
// Sample input stream and debounced finger status outputs of the conditioner.
interface flex_finger_conditioner_if #(
  parameter int DATA_W = 10
);
  logic              sample_valid;
  logic [2:0]        sample_finger;
  logic [DATA_W-1:0] sample_data;
  logic              error_clr;
  logic              thumb_status;
  logic              index_status;
  logic              middle_status;
  logic              ring_status;
  logic              pinky_status;
  logic              status_changed;
  logic              index_error;

  modport master (
    output sample_valid, sample_finger, sample_data, error_clr,
    input  thumb_status, index_status, middle_status, ring_status, pinky_status,
           status_changed, index_error
  );

  modport slave (
    input  sample_valid, sample_finger, sample_data, error_clr,
    output thumb_status, index_status, middle_status, ring_status, pinky_status,
           status_changed, index_error
  );
endinterface

// File: rtl/flex_finger_conditioner_finger_debounce.sv
// One finger's debounce counter and status; with FLEX_STALE_TIMEOUT_EN defined it
// also carries a stale-sample timer that forces the status straight.
module finger_debounce
  import flex_finger_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_N = 3
`ifdef FLEX_STALE_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 4096
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic hit_i,
  input  cls_e cls_i,
  input  logic clear_i,
  output logic status_o,
  output logic flip_o
);

  logic       status_q, status_d;
  logic [3:0] cnt_q, cnt_d;
  logic       flip_q, flip_d;
  logic       target;
  logic [3:0] cnt_inc;

  assign cnt_inc = cnt_q + 4'd1;

  always_comb begin
    case (cls_i)
      CLS_BENT:     target = 1'b1;
      CLS_STRAIGHT: target = 1'b0;
      default:      target = status_q;
    endcase
  end

`ifdef FLEX_STALE_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT_CYC);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             stale;

  // Fires once, on the cycle the timer reaches TIMEOUT_CYC; it then saturates.
  assign stale = (tmr_q == TMR_LAST);

  always_comb begin
    tmr_d = tmr_q;
    if (hit_i || clear_i)    tmr_d = '0;
    else if (tmr_q != TMR_MAX) tmr_d = tmr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tmr_q <= '0;
    else      tmr_q <= tmr_d;
  end
`else
  logic stale;
  assign stale = 1'b0;
`endif

  always_comb begin
    status_d = status_q;
    cnt_d    = cnt_q;
    flip_d   = 1'b0;
    if (clear_i) begin
      status_d = 1'b0;
      cnt_d    = '0;
    end else if (hit_i) begin
      if (target == status_q) begin
        cnt_d = '0;
      end else if (cnt_inc == 4'(DEBOUNCE_N)) begin
        status_d = ~status_q;
        cnt_d    = '0;
        flip_d   = 1'b1;
      end else begin
        cnt_d = cnt_inc;
      end
    end else if (stale) begin
      status_d = 1'b0;
      cnt_d    = '0;
      flip_d   = status_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      status_q <= 1'b0;
      cnt_q    <= '0;
      flip_q   <= 1'b0;
    end else begin
      status_q <= status_d;
      cnt_q    <= cnt_d;
      flip_q   <= flip_d;
    end
  end

  assign status_o = status_q;
  assign flip_o   = flip_q;

endmodule

// File: rtl/flex_finger_conditioner.sv
// Classifies multiplexed flex-sensor samples and debounces them into five finger
// status bits. Optional stale timeout: define FLEX_STALE_TIMEOUT_EN.
module flex_finger_conditioner
  import flex_finger_conditioner_pkg::*;
#(
  parameter int DATA_W      = 10,
  parameter int HI_THRESH   = 600,
  parameter int LO_THRESH   = 400,
  parameter int DEBOUNCE_N  = 3,
  parameter int TIMEOUT_CYC = 4096
) (
  input logic                      clk,
  input logic                      rst,
  flex_finger_conditioner_if.slave bus
);

  if (LO_THRESH >= HI_THRESH || DEBOUNCE_N < 1 || DEBOUNCE_N > 15 || TIMEOUT_CYC < 1)
  begin : g_bad_cfg
    $error("flex_finger_conditioner: illegal parameter set");
  end

  localparam logic [DATA_W-1:0] HI_Q = DATA_W'(HI_THRESH);
  localparam logic [DATA_W-1:0] LO_Q = DATA_W'(LO_THRESH);

  cls_e       cls_d, s1_cls_q;
  logic       s1_valid_d, s1_valid_q;
  logic [2:0] s1_finger_q;
  logic       index_error_d, index_error_q;

  logic [NUM_FINGERS-1:0] status;
  logic [NUM_FINGERS-1:0] flip;

  // Values equal to either threshold land in HOLD.
  always_comb begin
    cls_d = CLS_HOLD;
    if (bus.sample_data > HI_Q)      cls_d = CLS_BENT;
    else if (bus.sample_data < LO_Q) cls_d = CLS_STRAIGHT;
  end

  assign s1_valid_d = bus.sample_valid && finger_ok(bus.sample_finger);

  always_comb begin
    index_error_d = index_error_q;
    if (bus.sample_valid && !finger_ok(bus.sample_finger)) index_error_d = 1'b1;
    else if (bus.error_clr)                               index_error_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q    <= 1'b0;
      s1_finger_q   <= '0;
      s1_cls_q      <= CLS_HOLD;
      index_error_q <= 1'b0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_finger_q   <= bus.sample_finger;
      s1_cls_q      <= cls_d;
      index_error_q <= index_error_d;
    end
  end

  for (genvar i = 0; i < NUM_FINGERS; i++) begin : g_finger
    finger_debounce #(
      .DEBOUNCE_N (DEBOUNCE_N)
`ifdef FLEX_STALE_TIMEOUT_EN
      ,
      .TIMEOUT_CYC(TIMEOUT_CYC)
`endif
    ) u_debounce (
      .clk     (clk),
      .rst     (rst),
      .hit_i   (s1_valid_q && (s1_finger_q == 3'(i))),
      .cls_i   (s1_cls_q),
      .clear_i (1'b0),
      .status_o(status[i]),
      .flip_o  (flip[i])
    );
  end

  assign bus.thumb_status   = status[FINGER_THUMB];
  assign bus.index_status   = status[FINGER_INDEX];
  assign bus.middle_status  = status[FINGER_MIDDLE];
  assign bus.ring_status    = status[FINGER_RING];
  assign bus.pinky_status   = status[FINGER_PINKY];
  assign bus.status_changed = |flip;
  assign bus.index_error    = index_error_q;

endmodule

// File: tb/tb_flex_finger_conditioner.sv
// Self-checking bench: directed scenarios plus randomized samples against a
// per-sample reference model of the finger debounce rules.
module tb_flex_finger_conditioner;

  localparam int DATA_W = 10;
  localparam int HI     = 600;
  localparam int LO     = 400;
  localparam int DN     = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  flex_finger_conditioner_if #(.DATA_W(DATA_W)) bus ();

  flex_finger_conditioner #(
    .DATA_W(DATA_W), .HI_THRESH(HI), .LO_THRESH(LO), .DEBOUNCE_N(DN), .TIMEOUT_CYC(4096)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: state after every sample applied so far.
  bit m_st[5];
  int m_cnt[5];
  bit m_err;
  bit m_chg;

  // Expected outputs delayed to match when the DUT shows them.
  logic [4:0] st_d1, st_d2;
  bit chg_d1, chg_d2, err_d1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [4:0] dut_status();
    return {bus.pinky_status, bus.ring_status, bus.middle_status, bus.index_status,
            bus.thumb_status};
  endfunction

  function automatic logic [4:0] model_vec();
    logic [4:0] v;
    for (int k = 0; k < 5; k++) v[k] = m_st[k];
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 5; k++) begin
      m_st[k]  = 1'b0;
      m_cnt[k] = 0;
    end
    m_err  = 1'b0;
    m_chg  = 1'b0;
    st_d1  = '0;
    st_d2  = '0;
    chg_d1 = 1'b0;
    chg_d2 = 1'b0;
    err_d1 = 1'b0;
  endtask

  task automatic model_apply(input bit v, input int f, input int d, input bit clr);
    bit tgt;
    m_chg = 1'b0;
    if (v && f > 4) m_err = 1'b1;
    else if (clr)   m_err = 1'b0;
    if (v && f <= 4) begin
      if (d > HI)      tgt = 1'b1;
      else if (d < LO) tgt = 1'b0;
      else             tgt = m_st[f];
      if (tgt == m_st[f]) begin
        m_cnt[f] = 0;
      end else begin
        m_cnt[f] = m_cnt[f] + 1;
        if (m_cnt[f] == DN) begin
          m_st[f]  = tgt;
          m_cnt[f] = 0;
          m_chg    = 1'b1;
        end
      end
    end
  endtask

  // One clock: check outputs, then present the next input and advance the model.
  task automatic step(input bit v, input int f, input int d, input bit clr);
    @(negedge clk);
    check_val("status", 32'(dut_status()), 32'(st_d2));
    check_val("status_changed", 32'(bus.status_changed), 32'(chg_d2));
    check_val("index_error", 32'(bus.index_error), 32'(err_d1));
    st_d2  = st_d1;
    chg_d2 = chg_d1;
    bus.sample_valid  = v;
    bus.sample_finger = 3'(f);
    bus.sample_data   = DATA_W'(d);
    bus.error_clr     = clr;
    model_apply(v, f, d, clr);
    st_d1  = model_vec();
    chg_d1 = m_chg;
    err_d1 = m_err;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 0, 0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.sample_valid = 1'b0;
    bus.error_clr    = 1'b0;
    rst = 1'b0;
    #1;
    check_val("rst_status", 32'(dut_status()), 32'd0);
    check_val("rst_changed", 32'(bus.status_changed), 32'd0);
    check_val("rst_index_error", 32'(bus.index_error), 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  function automatic int pick_data();
    int sel;
    sel = int'($urandom_range(0, 7));
    case (sel)
      0: return 399;
      1: return 400;
      2: return 401;
      3: return 599;
      4: return 600;
      5: return 601;
      6: return int'($urandom_range(601, 1023));
      default: return int'($urandom_range(0, 399));
    endcase
  endfunction

  initial begin
    bus.sample_valid  = 1'b0;
    bus.sample_finger = '0;
    bus.sample_data   = '0;
    bus.error_clr     = 1'b0;
    model_reset();
    do_reset();

    // Thumb: three bent samples flip it.
    repeat (3) step(1'b1, 0, 700, 1'b0);
    idle(3);
    check_val("thumb_bent", 32'(bus.thumb_status), 32'd1);

    // Index: a HOLD sample in PENDING restarts the count.
    repeat (3) step(1'b1, 1, 700, 1'b0);
    idle(2);
    step(1'b1, 1, 300, 1'b0);
    step(1'b1, 1, 500, 1'b0);
    step(1'b1, 1, 300, 1'b0);
    step(1'b1, 1, 300, 1'b0);
    idle(2);
    check_val("index_still_bent", 32'(bus.index_status), 32'd1);
    step(1'b1, 1, 300, 1'b0);
    idle(3);
    check_val("index_straight", 32'(bus.index_status), 32'd0);

    // Interleaved middle and ring.
    step(1'b1, 2, 700, 1'b0);
    step(1'b1, 3, 700, 1'b0);
    step(1'b1, 2, 700, 1'b0);
    step(1'b1, 3, 300, 1'b0);
    step(1'b1, 2, 700, 1'b0);
    idle(3);
    check_val("middle_bent", 32'(bus.middle_status), 32'd1);
    check_val("ring_straight", 32'(bus.ring_status), 32'd0);

    // Invalid finger index and sticky error.
    step(1'b1, 6, 900, 1'b0);
    idle(3);
    check_val("err_set", 32'(bus.index_error), 32'd1);
    step(1'b0, 0, 0, 1'b1);
    idle(2);
    check_val("err_clr", 32'(bus.index_error), 32'd0);
    step(1'b1, 7, 900, 1'b1);
    idle(2);
    check_val("err_set_wins", 32'(bus.index_error), 32'd1);
    step(1'b0, 0, 0, 1'b1);

    // Pinky: reset mid-stream discards the partial count.
    repeat (2) step(1'b1, 4, 700, 1'b0);
    do_reset();
    step(1'b1, 4, 700, 1'b0);
    idle(3);
    check_val("pinky_after_rst", 32'(bus.pinky_status), 32'd0);

    // Randomized traffic, with one reset in the middle.
    for (int n = 0; n < 3000; n++) begin
      bit v;
      int f;
      v = ($urandom_range(0, 3) != 0);
      f = ($urandom_range(0, 15) < 14) ? int'($urandom_range(0, 4))
                                        : int'($urandom_range(5, 7));
      step(v, f, pick_data(), ($urandom_range(0, 15) == 0));
      if (n == 1500) do_reset();
    end
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
